alu_op_sequencer: RTL and testbench

- Sequential front/back stage wrapped around the 7-bit ALU datapath.
- Collects operand A, operand B and the opcode from a shared 7-bit entry bus over three load strobes, then presents them to the ALU.
- Captures the ALU result and flags in a registered output, with a valid/acknowledge handshake and a chaining mode that feeds the result back as the next A.
- Keeps a saturating count of overflowing arithmetic operations.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 48 ++++
 rtl/sat_counter.sv | 27 ++
 rtl/alu_op_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the 7-bit ALU and its operand sequencer: opcodes, FSM states, width.
package alu_pkg;

   localparam int ALU_WIDTH = 7;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_t;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_GOT_A = 3'd1,
      S_GOT_B = 3'd2,
      S_EXEC  = 3'd3,
      S_DONE  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/alu.sv
// Combinational WIDTH-bit ALU: add/sub/and/or with carry, overflow, zero, negative.
// Zero latency, no flow control; for sub, carry reports an unsigned borrow.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [1:0]       i_op,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_ovf,
   output logic             o_zero,
   output logic             o_neg
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      o_ovf    = 1'b0;
      case (alu_op_t'(i_op))
         OP_ADD: begin
            o_result = w_sum[WIDTH-1:0];
            o_carry  = w_sum[WIDTH];
            o_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_SUB: begin
            o_result = w_diff[WIDTH-1:0];
            o_carry  = w_diff[WIDTH];
            o_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
         end
         OP_AND: o_result = i_a & i_b;
         OP_OR:  o_result = i_a | i_b;
         default: o_result = '0;
      endcase
   end

   assign o_zero = (o_result == '0);
   assign o_neg  = o_result[WIDTH-1];

endmodule

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; one-cycle update latency.
// Increments beyond all-ones are dropped; clear has priority over increment.
module sat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_inc,
   input  logic         i_clear,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/alu_op_sequencer.sv
// Loads A, B, opcode from a shared bus, runs one EXEC cycle, holds the result until ack/load.
// Result valid 2 edges after the opcode strobe; consumer stalls by withholding ack, chain reuses res as A.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH     = ALU_WIDTH,
   parameter int OVF_CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     din,
   input  logic                 load,
   input  logic                 chain,
   input  logic                 clear,
   input  logic                 ack,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [1:0]           alu_op,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_carry,
   input  logic                 alu_ovf,
   input  logic                 alu_zero,
   input  logic                 alu_neg,
   output logic [WIDTH-1:0]     res,
   output logic                 res_carry,
   output logic                 res_ovf,
   output logic                 res_zero,
   output logic                 res_neg,
   output logic                 res_valid,
   output logic                 busy,
   output logic [OVF_CNT_W-1:0] ovf_count
);

   seq_state_t       r_state;
   seq_state_t       w_next;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [1:0]       r_alu_op;
   logic [WIDTH-1:0] r_res;
   logic             r_res_carry;
   logic             r_res_ovf;
   logic             r_res_zero;
   logic             r_res_neg;
   logic             r_res_valid;
   logic             w_ovf_inc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (clear) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (load) w_next = S_GOT_A;
            S_GOT_A: if (load) w_next = S_GOT_B;
            S_GOT_B: if (load) w_next = S_EXEC;
            S_EXEC:  w_next = S_DONE;
            S_DONE: begin
               if (load) begin
                  w_next = chain ? S_GOT_B : S_GOT_A;
               end else if (ack) begin
                  w_next = S_IDLE;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= '0;
         r_res       <= '0;
         r_res_carry <= 1'b0;
         r_res_ovf   <= 1'b0;
         r_res_zero  <= 1'b0;
         r_res_neg   <= 1'b0;
         r_res_valid <= 1'b0;
      end else if (clear) begin
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_op    <= '0;
         r_res       <= '0;
         r_res_carry <= 1'b0;
         r_res_ovf   <= 1'b0;
         r_res_zero  <= 1'b0;
         r_res_neg   <= 1'b0;
         r_res_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:  if (load) r_alu_a <= din;
            S_GOT_A: if (load) r_alu_b <= din;
            S_GOT_B: if (load) r_alu_op <= din[1:0];
            S_EXEC: begin
               r_res       <= alu_result;
               r_res_carry <= alu_carry;
               r_res_ovf   <= alu_ovf;
               r_res_zero  <= alu_zero;
               r_res_neg   <= alu_neg;
               r_res_valid <= 1'b1;
            end
            S_DONE: begin
               // load outranks ack so a back-to-back producer never loses a strobe
               if (load) begin
                  r_res_valid <= 1'b0;
                  if (chain) begin
                     r_alu_a <= r_res;
                     r_alu_b <= din;
                  end else begin
                     r_alu_a <= din;
                  end
               end else if (ack) begin
                  r_res_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign w_ovf_inc = (r_state == S_EXEC) && alu_ovf && !clear;

   sat_counter #(
      .W (OVF_CNT_W)
   ) u_ovf_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_inc   (w_ovf_inc),
      .i_clear (clear),
      .o_count (ovf_count)
   );

   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign res       = r_res;
   assign res_carry = r_res_carry;
   assign res_ovf   = r_res_ovf;
   assign res_zero  = r_res_zero;
   assign res_neg   = r_res_neg;
   assign res_valid = r_res_valid;
   assign busy      = (r_state == S_GOT_A) || (r_state == S_GOT_B) || (r_state == S_EXEC);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with the real ALU closing the loop.
module tb_alu_op_sequencer;

   localparam int W = 7;

   logic         clk;
   logic         reset;
   logic [W-1:0] din;
   logic         load;
   logic         chain;
   logic         clear;
   logic         ack;
   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [1:0]   alu_op;
   logic [W-1:0] alu_result;
   logic         alu_carry;
   logic         alu_ovf;
   logic         alu_zero;
   logic         alu_neg;
   logic [W-1:0] res;
   logic         res_carry;
   logic         res_ovf;
   logic         res_zero;
   logic         res_neg;
   logic         res_valid;
   logic         busy;
   logic [3:0]   ovf_count;

   int n_checks = 0;
   int n_errors = 0;

   alu_op_sequencer #(.WIDTH(W), .OVF_CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .din        (din),
      .load       (load),
      .chain      (chain),
      .clear      (clear),
      .ack        (ack),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_carry  (alu_carry),
      .alu_ovf    (alu_ovf),
      .alu_zero   (alu_zero),
      .alu_neg    (alu_neg),
      .res        (res),
      .res_carry  (res_carry),
      .res_ovf    (res_ovf),
      .res_zero   (res_zero),
      .res_neg    (res_neg),
      .res_valid  (res_valid),
      .busy       (busy),
      .ovf_count  (ovf_count)
   );

   alu #(.WIDTH(W)) u_alu (
      .i_a      (alu_a),
      .i_b      (alu_b),
      .i_op     (alu_op),
      .o_result (alu_result),
      .o_carry  (alu_carry),
      .o_ovf    (alu_ovf),
      .o_zero   (alu_zero),
      .o_neg    (alu_neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [1:0]   op;
      logic [W-1:0] r;
      logic         c;
      logic         v;
      logic         z;
      logic         n;
      logic [3:0]   cnt;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [W-1:0] d, input logic ch);
      din   = d;
      chain = ch;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      chain = 1'b0;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      strobe(a, 1'b0);
      strobe(b, 1'b0);
      strobe({5'b0, op}, 1'b0);
      chk("exec_busy", busy, 1);
      chk("exec_valid_low", res_valid, 0);
      tick();
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_a"}, alu_a, 0);
      chk({tag, "_alu_b"}, alu_b, 0);
      chk({tag, "_alu_op"}, alu_op, 0);
      chk({tag, "_res"}, res, 0);
      chk({tag, "_flags"}, {res_carry, res_ovf, res_zero, res_neg}, 0);
      chk({tag, "_valid"}, res_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ovf_count"}, ovf_count, 0);
   endtask

   initial begin
      int exp_cnt;
      vecs[0] = '{7'b0010100, 7'b0011110, 2'b00, 7'b0110010, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      vecs[1] = '{7'b1101100, 7'b0011110, 2'b01, 7'b1001110, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
      vecs[2] = '{7'b1001110, 7'b0011110, 2'b01, 7'b0110000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1};
      vecs[3] = '{7'b1010101, 7'b0101010, 2'b10, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
      vecs[4] = '{7'b1010101, 7'b0101010, 2'b11, 7'b1111111, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1};
      vecs[5] = '{7'd100,     7'd100,     2'b00, 7'b1001000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1};
      vecs[6] = '{7'd63,      7'd1,       2'b00, 7'b1000000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2};
      vecs[7] = '{7'd5,       7'd5,       2'b01, 7'b0000000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2};
      vecs[8] = '{7'd3,       7'd5,       2'b01, 7'b1111110, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2};

      reset = 1'b1;
      din   = '0;
      load  = 1'b0;
      chain = 1'b0;
      clear = 1'b0;
      ack   = 1'b0;
      #12;
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      for (int i = 0; i < 9; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].op);
         chk($sformatf("v%0d_res", i), res, vecs[i].r);
         chk($sformatf("v%0d_flags_cvzn", i), {res_carry, res_ovf, res_zero, res_neg},
             {vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].n});
         chk($sformatf("v%0d_valid", i), res_valid, 1);
         chk($sformatf("v%0d_busy", i), busy, 0);
         chk($sformatf("v%0d_ovf_count", i), ovf_count, vecs[i].cnt);
         tick();
         chk($sformatf("v%0d_hold_valid", i), res_valid, 1);
         chk($sformatf("v%0d_hold_res", i), res, vecs[i].r);
         do_ack();
         chk($sformatf("v%0d_ack_valid", i), res_valid, 0);
         chk($sformatf("v%0d_ack_busy", i), busy, 0);
         chk($sformatf("v%0d_ack_res_held", i), res, vecs[i].r);
      end

      // Saturation of the overflow counter
      exp_cnt = 2;
      for (int i = 0; i < 20; i++) begin
         do_op(7'b1001110, 7'b0011110, 2'b01);
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         chk($sformatf("sat%0d_ovf_count", i), ovf_count, exp_cnt);
         do_ack();
      end

      // Asynchronous reset in GOT_B, away from any clock edge
      strobe(7'd20, 1'b0);
      strobe(7'd30, 1'b0);
      chk("pre_reset_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("async_reset");
      #1;
      reset = 1'b0;
      strobe(7'd9, 1'b0);
      chk("post_reset_gota_busy", busy, 1);
      chk("post_reset_alu_a", alu_a, 7'd9);
      chk("post_reset_alu_b", alu_b, 0);
      clear = 1'b1;
      tick();
      clear = 1'b0;

      // Chain with a same-cycle ack, plus load ignored during EXEC
      do_op(7'd20, 7'd30, 2'b00);
      chk("chain_base_res", res, 7'd50);
      din   = 7'b0001010;
      chain = 1'b1;
      ack   = 1'b1;
      load  = 1'b1;
      tick();
      load  = 1'b0;
      chain = 1'b0;
      ack   = 1'b0;
      chk("chain_valid_drop", res_valid, 0);
      chk("chain_busy", busy, 1);
      chk("chain_alu_a", alu_a, 7'd50);
      chk("chain_alu_b", alu_b, 7'd10);
      chk("chain_res_held", res, 7'd50);
      din  = 7'b0000000;
      load = 1'b1;
      tick();
      din = 7'b1010101;
      tick();
      load = 1'b0;
      chk("chain_res", res, 7'b0111100);
      chk("chain_valid", res_valid, 1);
      chk("exec_load_ignored_a", alu_a, 7'd50);
      chk("exec_load_ignored_b", alu_b, 7'd10);
      chk("exec_load_ignored_op", alu_op, 2'b00);
      chk("exec_load_ignored_busy", busy, 0);

      // Non-chained load from DONE restarts at GOT_A
      strobe(7'd7, 1'b0);
      chk("nochain_valid_drop", res_valid, 0);
      chk("nochain_alu_a", alu_a, 7'd7);
      chk("nochain_busy", busy, 1);
      chk("gota_res_held", res, 7'b0111100);
      strobe(7'd9, 1'b0);
      chk("gotb_res_held", res, 7'b0111100);
      strobe(7'b1111101, 1'b1);
      chk("op_upper_bits_ignored", alu_op, 2'b01);
      tick();
      chk("nochain_res", res, 7'b1111110);
      chk("nochain_flags_cvzn", {res_carry, res_ovf, res_zero, res_neg}, 4'b1001);
      do_ack();

      // Synchronous clear with a simultaneous load in GOT_B
      do_op(7'b1001110, 7'b0011110, 2'b01);
      chk("pre_clear_ovf_count", ovf_count, 1);
      do_ack();
      strobe(7'd20, 1'b0);
      strobe(7'd30, 1'b0);
      din   = 7'd1;
      load  = 1'b1;
      clear = 1'b1;
      #2;
      chk("clear_not_async", alu_b, 7'd30);
      tick();
      load  = 1'b0;
      clear = 1'b0;
      chk_all_zero("clear_gotb");

      // Clear from DONE
      do_op(7'd20, 7'd30, 2'b00);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk_all_zero("clear_done");
      strobe(7'd5, 1'b0);
      chk("post_clear_alu_a", alu_a, 7'd5);
      chk("post_clear_busy", busy, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
